// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_pkg                                                       |
// | Brief  : Shared types and helpers for the multi-port register file:        |
// |          dump-engine state encoding and the read-source selection used by  |
// |          every read port and by the dump loader.                           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  // Dump engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  // Where a registered read takes its next value from.
  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_WDATA = 2'd1,
    SRC_ZERO  = 2'd2
  } rd_src_e;

  // Read-with-bypass selection. A hardwired-zero hit wins over everything,
  // so a dropped r0 write can never leak through the bypass path. wr_en must
  // already have the dropped-r0 write masked out.
  function automatic rd_src_e read_src(input logic zero_hit,
                                       input logic wr_en,
                                       input logic addr_hit);
    if (zero_hit) begin
      return SRC_ZERO;
    end
    if (wr_en && addr_hit) begin
      return SRC_WDATA;
    end
    return SRC_ARRAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_dump_fsm                                                  |
// | Brief  : Sequencer that walks every register index over a valid/ready      |
// |          handshake. It only produces indices and a load strobe; the data   |
// |          register and the array live in the parent.                        |
// | Ports  : CLK, reset     clock / synchronous active-high reset              |
// |          start          1-cycle dump request (ignored unless IDLE)         |
// |          ready          consumer accepts current beat                      |
// |          busy, valid    dump in progress / beat valid                      |
// |          done           1-cycle pulse after last beat accepted             |
// |          idx            index of the current beat                          |
// |          load, load_idx parent must load beat data for load_idx this edge  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          ready,
  output logic          busy,
  output logic          valid,
  output logic          done,
  output logic [AW-1:0] idx,
  output logic          load,
  output logic [AW-1:0] load_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  dump_state_e state;
  logic        handshake;
  logic        at_last;

  assign handshake = valid && ready;
  assign at_last   = (idx == LAST_IDX);

  // Beat data is loaded on the same edge the index advances, so the data
  // register is only touched on start or on an accepted non-final beat.
  // Without a handshake nothing reloads, which keeps the beat stable even if
  // the underlying register is overwritten while stalled.
  always_comb begin
    load     = 1'b0;
    load_idx = '0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          load_idx = '0;
        end
      end
      SEND: begin
        if (handshake && !at_last) begin
          load     = 1'b1;
          load_idx = idx + 1'b1;
        end
      end
      default: begin
        load     = 1'b0;
        load_idx = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SEND;
            busy  <= 1'b1;
            valid <= 1'b1;
            idx   <= '0;
          end
        end
        SEND: begin
          if (handshake) begin
            if (at_last) begin
              state <= DONE;
              busy  <= 1'b0;
              valid <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here: requests are never queued.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_mp                                                        |
// | Brief  : Parametrised CPU register file, one write port, NUM_RD registered |
// |          read ports with write-to-read bypass, optional hardwired-zero r0, |
// |          a display read port and a register dump streaming engine.         |
// | Ports  : CLK, reset           clock / synchronous active-high reset        |
// |          we, waddr, wdata     write port                                   |
// |          raddr, rdata         packed read ports, port k at [k*W +: W]      |
// |          disp_addr, disp_data display read port                            |
// |          dump_start           1-cycle request to stream all registers      |
// |          dump_busy/valid/done dump status and handshake                    |
// |          dump_ready           consumer accepts beat                        |
// |          dump_idx, dump_data  current beat                                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int NUM_REGS = 8,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic [AW-1:0]            disp_addr,
  output logic [DATA_W-1:0]        disp_data,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [AW-1:0]            dump_idx,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              we_eff;
  logic              dump_load;
  logic [AW-1:0]     dump_load_idx;

  // A write to r0 in hardwired-zero mode is dropped entirely, including its
  // bypass, so everything downstream uses the masked enable.
  assign we_eff = we && !((ZERO_REG != 0) && (waddr == '0));

  // Next value of any registered read of address a: zero, bypassed write data
  // or the stored register.
  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0]     a,
                                                  input logic [DATA_W-1:0] stored,
                                                  input logic              wr_en,
                                                  input logic [AW-1:0]     wr_addr,
                                                  input logic [DATA_W-1:0] wr_data);
    logic zero_hit;
    zero_hit = (ZERO_REG != 0) && (a == '0);
    case (read_src(zero_hit, wr_en, wr_addr == a))
      SRC_ZERO:  return '0;
      SRC_WDATA: return wr_data;
      default:   return stored;
    endcase
  endfunction

  // Reset and write share one block so the array has a single driver.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_eff) begin
      regs[waddr] <= wdata;
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] q;

      assign addr = raddr[k*AW +: AW];

      always_ff @(posedge CLK) begin
        if (reset) begin
          q <= '0;
        end else begin
          q <= read_port(addr, regs[addr], we_eff, waddr, wdata);
        end
      end

      assign rdata[k*DATA_W +: DATA_W] = q;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (reset) begin
      disp_data <= '0;
    end else begin
      disp_data <= read_port(disp_addr, regs[disp_addr], we_eff, waddr, wdata);
    end
  end

  regfile_dump_fsm #(
    .NUM_REGS (NUM_REGS)
  ) u_dump_fsm (
    .CLK      (CLK),
    .reset    (reset),
    .start    (dump_start),
    .ready    (dump_ready),
    .busy     (dump_busy),
    .valid    (dump_valid),
    .done     (dump_done),
    .idx      (dump_idx),
    .load     (dump_load),
    .load_idx (dump_load_idx)
  );

  // Beat data only changes when the sequencer asks for it, so a stalled beat
  // holds its captured value.
  always_ff @(posedge CLK) begin
    if (reset) begin
      dump_data <= '0;
    end else if (dump_load) begin
      dump_data <= read_port(dump_load_idx, regs[dump_load_idx], we_eff, waddr, wdata);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_regfile_mp                                                     |
// | Brief  : Self-checking bench for regfile_mp. Two instances share stimulus: |
// |          one with ZERO_REG=0 (a) and one with ZERO_REG=1 (z).              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int NRD = 2;
  localparam int AW  = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [DW-1:0]     wdata = '0;
  logic [NRD*AW-1:0] raddr = '0;
  logic [AW-1:0]     disp_addr = '0;
  logic              dump_start = 1'b0;
  logic              dump_ready = 1'b0;

  logic [NRD*DW-1:0] rdata_a, rdata_z;
  logic [DW-1:0]     disp_a, disp_z, ddata_a, ddata_z;
  logic              busy_a, busy_z, valid_a, valid_z, done_a, done_z;
  logic [AW-1:0]     idx_a, idx_z;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(0)) dut_a (
    .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .disp_addr(disp_addr), .disp_data(disp_a),
    .dump_start(dump_start), .dump_busy(busy_a), .dump_valid(valid_a),
    .dump_ready(dump_ready), .dump_idx(idx_a), .dump_data(ddata_a), .dump_done(done_a)
  );

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(1)) dut_z (
    .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_z), .disp_addr(disp_addr), .disp_data(disp_z),
    .dump_start(dump_start), .dump_busy(busy_z), .dump_valid(valid_z),
    .dump_ready(dump_ready), .dump_idx(idx_z), .dump_data(ddata_z), .dump_done(done_z)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register contents, expected read outputs, dump progress.
  logic [DW-1:0] mem_a [NR];
  logic [DW-1:0] mem_z [NR];
  logic [DW-1:0] e_rd_a [NRD];
  logic [DW-1:0] e_rd_z [NRD];
  logic [DW-1:0] e_disp_a, e_disp_z;
  bit            d_act, d_done;
  int            d_idx;
  logic [DW-1:0] d_val_a, d_val_z;

  // Value a read of address a sees at the coming edge.
  function automatic logic [DW-1:0] mrd(input bit zr, input logic [AW-1:0] a);
    if (zr && a == 0) return '0;
    if (we && waddr == a) return wdata;
    return zr ? mem_z[a] : mem_a[a];
  endfunction

  // Advance the model by one clock using the current inputs, then clock.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < NR; i++) begin mem_a[i] = '0; mem_z[i] = '0; end
      for (int k = 0; k < NRD; k++) begin e_rd_a[k] = '0; e_rd_z[k] = '0; end
      e_disp_a = '0; e_disp_z = '0;
      d_act = 0; d_done = 0; d_idx = 0; d_val_a = '0; d_val_z = '0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        e_rd_a[k] = mrd(0, raddr[k*AW +: AW]);
        e_rd_z[k] = mrd(1, raddr[k*AW +: AW]);
      end
      e_disp_a = mrd(0, disp_addr);
      e_disp_z = mrd(1, disp_addr);
      if (d_act) begin
        if (dump_ready) begin
          if (d_idx == NR - 1) begin
            d_act = 0; d_done = 1;
          end else begin
            d_idx = d_idx + 1;
            d_val_a = mrd(0, AW'(d_idx));
            d_val_z = mrd(1, AW'(d_idx));
          end
        end
      end else if (d_done) begin
        d_done = 0;
      end else if (dump_start) begin
        d_act = 1; d_idx = 0;
        d_val_a = mrd(0, '0);
        d_val_z = mrd(1, '0);
      end
      if (we) begin
        mem_a[waddr] = wdata;
        if (waddr != 0) mem_z[waddr] = wdata;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; we = 1; waddr = 3'd5; wdata = 16'hFFFF; dump_start = 1; dump_ready = 1;
    tick();
    total++;
    if ({busy_a, valid_a, done_a} !== 3'b000 || idx_a !== 3'd0 || ddata_a !== 16'h0) begin
      bad++;
      $display("FAIL reset_dump busy/valid/done=%b idx=%0d data=%h required 000/0/0000",
               {busy_a, valid_a, done_a}, idx_a, ddata_a);
    end
    reset = 0; we = 0; dump_start = 0;
    for (int i = 0; i < NR; i++) begin
      raddr = {AW'(i), AW'(i)}; disp_addr = AW'(i);
      tick();
      total++;
      if (rdata_a !== '0 || rdata_z !== '0 || disp_a !== '0 || disp_z !== '0 || valid_a !== 1'b0) begin
        bad++;
        $display("FAIL reset_read idx=%0d rdata_a=%h rdata_z=%h disp_a=%h valid=%b required all 0",
                 i, rdata_a, rdata_z, disp_a, valid_a);
      end
    end
  endtask

  task automatic test_bypass();
    we = 1; waddr = 3'd3; wdata = 16'hBEEF; raddr = {3'd4, 3'd3};
    tick();
    we = 0;
    total++;
    if (rdata_a[0 +: DW] !== 16'hBEEF) begin
      bad++; $display("FAIL bypass_port0 got %h required BEEF", rdata_a[0 +: DW]);
    end
    total++;
    if (rdata_a[DW +: DW] !== 16'h0000) begin
      bad++; $display("FAIL bypass_port1 got %h required 0000", rdata_a[DW +: DW]);
    end
    raddr = {3'd3, 3'd4}; disp_addr = 3'd3;
    tick();
    total++;
    if (rdata_a[DW +: DW] !== 16'hBEEF || disp_a !== 16'hBEEF) begin
      bad++; $display("FAIL stored_read port1=%h disp=%h required BEEF", rdata_a[DW +: DW], disp_a);
    end
  endtask

  task automatic test_zero_reg();
    we = 1; waddr = 3'd0; wdata = 16'h1234; raddr = {3'd0, 3'd0}; disp_addr = 3'd0;
    tick();
    we = 0;
    total++;
    if (rdata_z[0 +: DW] !== 16'h0 || disp_z !== 16'h0) begin
      bad++; $display("FAIL zero_bypass rdata=%h disp=%h required 0000", rdata_z[0 +: DW], disp_z);
    end
    total++;
    if (rdata_a[0 +: DW] !== 16'h1234) begin
      bad++; $display("FAIL nonzero_cfg_bypass got %h required 1234", rdata_a[0 +: DW]);
    end
    tick();
    total++;
    if (rdata_z[DW +: DW] !== 16'h0 || rdata_a[DW +: DW] !== 16'h1234) begin
      bad++; $display("FAIL zero_stored z=%h a=%h required 0000/1234", rdata_z[DW +: DW], rdata_a[DW +: DW]);
    end
  endtask

  task automatic test_dump_full();
    for (int i = 0; i < NR; i++) begin
      we = 1; waddr = AW'(i); wdata = 16'h0100 + DW'(i);
      tick();
    end
    we = 0; dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    for (int b = 0; b < NR; b++) begin
      total++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || idx_a !== AW'(b) || ddata_a !== 16'h0100 + DW'(b)) begin
        bad++;
        $display("FAIL dump_beat%0d valid=%b busy=%b idx=%0d data=%h required 1/1/%0d/%h",
                 b, valid_a, busy_a, idx_a, ddata_a, b, 16'h0100 + b);
      end
      total++;
      if (ddata_z !== ((b == 0) ? 16'h0 : 16'h0100 + DW'(b))) begin
        bad++; $display("FAIL dump_zero_beat%0d got %h", b, ddata_z);
      end
      if (b == 3) dump_start = 1;   // must be ignored while busy
      tick();
      dump_start = 0;
    end
    total++;
    if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL dump_done done=%b valid=%b busy=%b required 1/0/0", done_a, valid_a, busy_a);
    end
    dump_start = 1;                 // must be ignored in DONE
    tick();
    dump_start = 0;
    total++;
    if (done_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width done=%b valid=%b required 0/0", done_a, valid_a);
    end
    tick();
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL start_in_done_queued valid=%b busy=%b required 0/0", valid_a, busy_a);
    end
  endtask

  task automatic test_dump_stall();
    dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    tick();
    tick();
    dump_ready = 0; we = 1; waddr = 3'd2; wdata = 16'hAAAA; raddr = {3'd2, 3'd0};
    for (int s = 0; s < 3; s++) begin
      tick();
      we = 0;
      total++;
      if (valid_a !== 1'b1 || idx_a !== 3'd2 || ddata_a !== 16'h0102) begin
        bad++;
        $display("FAIL stall_hold%0d valid=%b idx=%0d data=%h required 1/2/0102", s, valid_a, idx_a, ddata_a);
      end
      if (s == 0) begin
        total++;
        if (rdata_a[DW +: DW] !== 16'hAAAA) begin
          bad++; $display("FAIL stall_read_bypass got %h required AAAA", rdata_a[DW +: DW]);
        end
      end
    end
    dump_ready = 1;
    for (int b = 3; b < NR; b++) begin
      tick();
      total++;
      if (idx_a !== AW'(b) || ddata_a !== 16'h0100 + DW'(b)) begin
        bad++; $display("FAIL stall_resume idx=%0d data=%h required %0d/%h", idx_a, ddata_a, b, 16'h0100 + b);
      end
    end
    tick();
    total++;
    if (done_a !== 1'b1) begin
      bad++; $display("FAIL stall_done got %b required 1", done_a);
    end
    raddr = {3'd0, 3'd2};
    tick();
    total++;
    if (rdata_a[0 +: DW] !== 16'hAAAA) begin
      bad++; $display("FAIL after_stall_read got %h required AAAA", rdata_a[0 +: DW]);
    end
  endtask

  task automatic test_dump_reset();
    dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (idx_a !== 3'd5) begin
      bad++; $display("FAIL abort_setup idx=%0d required 5", idx_a);
    end
    reset = 1; we = 1; waddr = 3'd6; wdata = 16'h5555; raddr = {3'd6, 3'd6};
    tick();
    reset = 0; we = 0;
    total++;
    if ({busy_a, valid_a, done_a} !== 3'b000 || idx_a !== 3'd0 || ddata_a !== 16'h0) begin
      bad++;
      $display("FAIL abort_state busy/valid/done=%b idx=%0d data=%h required 000/0/0000",
               {busy_a, valid_a, done_a}, idx_a, ddata_a);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (done_a !== 1'b0 || valid_a !== 1'b0 || rdata_a[0 +: DW] !== 16'h0) begin
        bad++; $display("FAIL abort_after%0d done=%b valid=%b r6=%h required 0/0/0000", i, done_a, valid_a, rdata_a[0 +: DW]);
      end
    end
  endtask

  task automatic test_random_rw();
    dump_start = 0;
    for (int c = 0; c < 150; c++) begin
      we = 1'($urandom_range(0, 1)); waddr = AW'($urandom); wdata = DW'($urandom);
      raddr = (NRD*AW)'($urandom); disp_addr = AW'($urandom); dump_ready = 1'($urandom_range(0, 1));
      tick();
      for (int k = 0; k < NRD; k++) begin
        total++;
        if (rdata_a[k*DW +: DW] !== e_rd_a[k] || rdata_z[k*DW +: DW] !== e_rd_z[k]) begin
          bad++;
          $display("FAIL rand_rd c=%0d port%0d a=%h z=%h required %h/%h",
                   c, k, rdata_a[k*DW +: DW], rdata_z[k*DW +: DW], e_rd_a[k], e_rd_z[k]);
        end
      end
      total++;
      if (disp_a !== e_disp_a || disp_z !== e_disp_z) begin
        bad++; $display("FAIL rand_disp c=%0d a=%h z=%h required %h/%h", c, disp_a, disp_z, e_disp_a, e_disp_z);
      end
    end
    we = 0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      dump_start = ($urandom_range(0, 5) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1)); waddr = AW'($urandom); wdata = DW'($urandom);
      tick();
      total++;
      if (valid_a !== d_act || busy_a !== d_act || done_a !== d_done ||
          valid_z !== d_act || done_z !== d_done) begin
        bad++;
        $display("FAIL b2b_ctrl c=%0d valid=%b busy=%b done=%b required %b/%b/%b",
                 c, valid_a, busy_a, done_a, d_act, d_act, d_done);
      end
      if (d_act) begin
        total++;
        if (idx_a !== AW'(d_idx) || ddata_a !== d_val_a || ddata_z !== d_val_z) begin
          bad++;
          $display("FAIL b2b_beat c=%0d idx=%0d a=%h z=%h required %0d/%h/%h",
                   c, idx_a, ddata_a, ddata_z, d_idx, d_val_a, d_val_z);
        end
      end
    end
    dump_start = 0; we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_dump_full();
    test_dump_stall();
    test_dump_reset();
    test_random_rw();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
